simd_pe_top: RTL and testbench
==============================

# simd_pe_top

Top-level SIMD matrix processing element: a small sequencer executes a program from an internal instruction memory. The program operates on two 128-bit-wide operand memories, A and B, using a 4-lane 32-bit dot-product datapath, and writes packed results to a result memory. It computes products such as C = A·Bᵀ for 8×8 matrices of 32-bit words. The block sits under the host/bench: the host preloads memories hierarchically, pulses `valid`, and waits for `stop`.

## Interface
- `DATA_W`, 32: lane word width.
- `LANES`, 4: lanes per memory row (row width = 128 bits).
- `MEM_DEPTH`, 16: rows in `ram_a`, `ram_b` and `ram_result`.
- `INST_DEPTH`, 256: instruction words; the program counter is 8 bits.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: reset, synchronous, active-high (port keeps the codebase name).
- `valid` in 1: start pulse, sampled only in IDLE or DONE.
- `stop` out 1: program reached HALT; reset value 0.

## Operation
- Memories live in instance `fetch_unit`, as unpacked arrays `ram_a`, `ram_b`, `ram_result` (each `[MEM_DEPTH]` of 128 bits) and `ram_inst` (`[INST_DEPTH]` of 32 bits), so benches can write them and `$readmemb` into them hierarchically.
- Memories are never reset.
- Operand row packing: lane k occupies bits [32k+31:32k]. An 8-word matrix row i is split across rows 2i (words 0–3) and 2i+1 (words 4–7).
- Result row packing: output word w occupies bits [127−32w : 96−32w]. Word 0 is in the MSBs.
- Instruction format: opcode [31:28], operand [7:0], other bits ignored.
  - 0 NOP: no effect.
  - 1 LDA: RA ← `ram_a[op[3:0]]`.
  - 2 LDB: RB ← `ram_b[op[3:0]]`.
  - 3 DOT: ACC ← ACC + Σ RA[l]·RB[l] over 4 lanes. All products and sums wrap modulo 2³².
  - 4 PUT: OUT[op[1:0]] ← ACC, then ACC ← 0.
  - 5 ST: `ram_result[op[3:0]]` ← {OUT[0], OUT[1], OUT[2], OUT[3]}.
  - 6 CLR: ACC ← 0 and OUT ← 0.
  - 7 HALT: enter DONE.
  - 8–15: treated as NOP.
- FSM states:
  - IDLE: on `valid`, PC ← 0, ACC/OUT/RA/RB ← 0, go to FETCH.
  - FETCH: IR ← `ram_inst[PC]`, go to EXEC.
  - EXEC: execute IR, PC ← PC+1 (wraps 255→0), go to FETCH. On HALT, go to DONE instead.
  - DONE: `stop` = 1. On `valid`, restart exactly as from IDLE.
- `valid` in FETCH/EXEC is ignored.
- Reset at any time: state ← IDLE; PC, IR, RA, RB, ACC, OUT ← 0; `stop` ← 0. Memory contents are kept, and a partially executed program is abandoned.

## Timing
- Every instruction takes 2 cycles (FETCH + EXEC).
- LDA/LDB/ST memory accesses complete at the EXEC edge. A following instruction sees the new value.
- `stop` is registered. It rises at the edge where HALT executes, which is 2 cycles after the edge sampling `valid` when HALT is at PC 0.
- `stop` stays high until reset or a restarting `valid`. It falls at the edge that samples `valid`.
- A program of N instructions followed by HALT raises `stop` 2(N+1) cycles after start.

## Configuration
- `PE_PERF_CNT_EN` defined:
  - Adds a 32-bit register `cycle_count` in `simd_pe_top`, readable hierarchically.
  - It clears on reset and on start, increments every cycle in FETCH/EXEC, and holds in DONE.
- Undefined: no counter. Functional behaviour is identical either way.

## Structure
- Package `pe_pkg` holds:
  - `DATA_W`, `LANES`, `ROW_W` = 128.
  - Opcode enum `pe_op_e`.
  - Struct `pe_inst_t` (opcode, operand).
  - FSM state enum `pe_state_e`.
- One sub-module, `pe_fetch_unit`, instantiated as `fetch_unit`. It owns the four memories and their read/write ports.
- The FSM and the DOT datapath stay in `simd_pe_top`.

## Test plan
- Identity test:
  - Load A = B = I₈ (`ram_a[2i]`/`[2i+1]` per packing) and run the 8×8 A·Bᵀ program (LDA/LDB/DOT pairs, PUT, ST).
  - After `stop`: word i of row i is 1 and all other words are 0. Row 0 reads {`ram_result[0]`, `ram_result[1]`} = 0x00000001 followed by seven zero words.
- HALT-only program: pulse `valid` → `stop` = 1 exactly 2 cycles after the sampling edge, and `ram_result` is unchanged.
- Wrap arithmetic:
  - RA = {2, 0xFFFFFFFF, 0, 0} and RB = {3, 2, 0, 0}, then DOT, PUT 0, ST 0.
  - Result: `ram_result[0][127:96]` = 0x00000004.
- `valid` pulsed mid-run is ignored: the run completes with the same `stop` time and results as a clean run.
- Reset asserted mid-program:
  - `stop` = 0 next cycle, and `ram_result` holds only rows written before reset.
  - A new `valid` reruns from PC 0 to the correct results.
- Restart from DONE: `valid` drops `stop` at the sampling edge, and the second run gives identical results.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types for the SIMD processing element: widths, opcodes, instruction
// fields and sequencer states.
package pe_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned ROW_W  = DATA_W * LANES;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDA  = 4'd1,
    OP_LDB  = 4'd2,
    OP_DOT  = 4'd3,
    OP_PUT  = 4'd4,
    OP_ST   = 4'd5,
    OP_CLR  = 4'd6,
    OP_HALT = 4'd7
  } pe_op_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] operand;
  } pe_inst_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE
  } pe_state_e;

  function automatic pe_inst_t decode_inst(input logic [31:0] word);
    pe_inst_t inst;
    inst.opcode  = word[31:28];
    inst.operand = word[7:0];
    return inst;
  endfunction

endpackage

// File: rtl/pe_fetch_unit.sv
// Memory block of the SIMD PE: instruction, operand A/B and result memories.
// Reads are combinational; only the result memory is written by the design.
module pe_fetch_unit #(
  parameter int unsigned ROW_W      = 128,
  parameter int unsigned MEM_DEPTH  = 16,
  parameter int unsigned INST_DEPTH = 256,
  parameter int unsigned MEM_AW     = 4,
  parameter int unsigned INST_AW    = 8
) (
  input  logic               clk,
  input  logic [INST_AW-1:0] inst_addr,
  output logic [31:0]        inst_rdata,
  input  logic [MEM_AW-1:0]  a_addr,
  output logic [ROW_W-1:0]   a_rdata,
  input  logic [MEM_AW-1:0]  b_addr,
  output logic [ROW_W-1:0]   b_rdata,
  input  logic               res_we,
  input  logic [MEM_AW-1:0]  res_addr,
  input  logic [ROW_W-1:0]   res_wdata
);

  logic [ROW_W-1:0] ram_a      [MEM_DEPTH];
  logic [ROW_W-1:0] ram_b      [MEM_DEPTH];
  logic [ROW_W-1:0] ram_result [MEM_DEPTH];
  logic [31:0]      ram_inst   [INST_DEPTH];

  assign inst_rdata = ram_inst[inst_addr];
  assign a_rdata    = ram_a[a_addr];
  assign b_rdata    = ram_b[b_addr];

  always_ff @(posedge clk) begin
    if (res_we) begin
      ram_result[res_addr] <= res_wdata;
    end
  end

endmodule

// File: rtl/simd_pe_top.sv
// SIMD matrix PE: FETCH/EXEC sequencer plus 4-lane dot-product datapath.
// Optional cycle counter enabled by defining PE_PERF_CNT_EN.
module simd_pe_top #(
  parameter int unsigned DATA_W     = pe_pkg::DATA_W,
  parameter int unsigned LANES      = pe_pkg::LANES,
  parameter int unsigned MEM_DEPTH  = 16,
  parameter int unsigned INST_DEPTH = 256
) (
  input  logic clk,
  input  logic rstn,
  input  logic valid,
  output logic stop
);

  import pe_pkg::*;

  localparam int unsigned ROW_BITS = DATA_W * LANES;
  localparam int unsigned MEM_AW   = $clog2(MEM_DEPTH);
  localparam int unsigned INST_AW  = $clog2(INST_DEPTH);
  localparam int unsigned LANE_AW  = $clog2(LANES);

  pe_state_e                       state_q, state_d;
  logic      [INST_AW-1:0]         pc_q, pc_d;
  pe_inst_t                        ir_q, ir_d;
  logic      [ROW_BITS-1:0]        ra_q, ra_d;
  logic      [ROW_BITS-1:0]        rb_q, rb_d;
  logic      [DATA_W-1:0]          acc_q, acc_d;
  logic      [LANES-1:0][DATA_W-1:0] out_q, out_d;
  logic                            stop_q, stop_d;

  logic [31:0]         inst_rdata;
  logic [ROW_BITS-1:0] a_rdata, b_rdata;
  logic                res_we;
  logic [ROW_BITS-1:0] res_wdata;
  logic [DATA_W-1:0]   dot_sum;
  logic                start;

  pe_fetch_unit #(
    .ROW_W      (ROW_BITS),
    .MEM_DEPTH  (MEM_DEPTH),
    .INST_DEPTH (INST_DEPTH),
    .MEM_AW     (MEM_AW),
    .INST_AW    (INST_AW)
  ) fetch_unit (
    .clk        (clk),
    .inst_addr  (pc_q),
    .inst_rdata (inst_rdata),
    .a_addr     (ir_q.operand[MEM_AW-1:0]),
    .a_rdata    (a_rdata),
    .b_addr     (ir_q.operand[MEM_AW-1:0]),
    .b_rdata    (b_rdata),
    .res_we     (res_we),
    .res_addr   (ir_q.operand[MEM_AW-1:0]),
    .res_wdata  (res_wdata)
  );

  assign start = valid && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Products and sums are truncated to the lane width, giving mod-2^32 wrap.
  always_comb begin
    dot_sum = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      dot_sum = dot_sum + ra_q[l*DATA_W +: DATA_W] * rb_q[l*DATA_W +: DATA_W];
    end
  end

  // Result rows hold OUT[0] in the MSBs, reversed relative to lane packing.
  always_comb begin
    res_wdata = '0;
    for (int unsigned w = 0; w < LANES; w++) begin
      res_wdata[ROW_BITS-1-w*DATA_W -: DATA_W] = out_q[w];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    out_d   = out_q;
    stop_d  = stop_q;
    res_we  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (valid) begin
          state_d = S_FETCH;
          pc_d    = '0;
          ra_d    = '0;
          rb_d    = '0;
          acc_d   = '0;
          out_d   = '0;
          stop_d  = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = decode_inst(inst_rdata);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        pc_d    = pc_q + 1'b1;
        state_d = S_FETCH;
        case (ir_q.opcode)
          OP_LDA: ra_d = a_rdata;
          OP_LDB: rb_d = b_rdata;
          OP_DOT: acc_d = acc_q + dot_sum;
          OP_PUT: begin
            out_d[ir_q.operand[LANE_AW-1:0]] = acc_q;
            acc_d = '0;
          end
          OP_ST:  res_we = 1'b1;
          OP_CLR: begin
            acc_d = '0;
            out_d = '0;
          end
          OP_HALT: begin
            state_d = S_DONE;
            stop_d  = 1'b1;
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      stop_q  <= stop_d;
    end
  end

  assign stop = stop_q;

`ifdef PE_PERF_CNT_EN
  logic [31:0] cycle_count, cycle_count_d;

  always_comb begin
    cycle_count_d = cycle_count;
    if (start) begin
      cycle_count_d = '0;
    end else if ((state_q == S_FETCH) || (state_q == S_EXEC)) begin
      cycle_count_d = cycle_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      cycle_count <= '0;
    end else begin
      cycle_count <= cycle_count_d;
    end
  end
`else
  logic unused_start;
  assign unused_start = start;
`endif

endmodule

// File: tb/tb_simd_pe_top.sv
// Bench for simd_pe_top: programs are interpreted by an instruction-level
// model and the result memory and stop timing compared against it.
module tb_simd_pe_top;

  logic clk   = 1'b0;
  logic rstn  = 1'b1;
  logic valid = 1'b0;
  logic stop;

  int total = 0;
  int bad   = 0;

  logic [31:0]  ma   [16][4];
  logic [31:0]  mb   [16][4];
  logic [127:0] mres [16];
  logic [31:0]  prog [$];

  always #5 clk = ~clk;

  simd_pe_top #(
    .DATA_W     (32),
    .LANES      (4),
    .MEM_DEPTH  (16),
    .INST_DEPTH (256)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .valid (valid),
    .stop  (stop)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int arg);
    return {op[3:0], 20'h0, arg[7:0]};
  endfunction

  task automatic push_mats();
    for (int r = 0; r < 16; r++) begin
      dut.fetch_unit.ram_a[r] = {ma[r][3], ma[r][2], ma[r][1], ma[r][0]};
      dut.fetch_unit.ram_b[r] = {mb[r][3], mb[r][2], mb[r][1], mb[r][0]};
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) dut.fetch_unit.ram_inst[i] = prog[i];
  endtask

  // C rows 4h..4h+3 of A*B^T; each C word takes two half-row DOTs.
  task automatic build_mat_prog(input int h);
    prog.delete();
    prog.push_back(enc(6, 0));
    for (int i = 4*h; i < 4*h + 4; i++) begin
      for (int j = 0; j < 8; j++) begin
        prog.push_back(enc(1, 2*i));
        prog.push_back(enc(2, 2*j));
        prog.push_back(enc(3, 0));
        prog.push_back(enc(1, 2*i + 1));
        prog.push_back(enc(2, 2*j + 1));
        prog.push_back(enc(3, 0));
        prog.push_back(enc(4, j % 4));
        if (j == 3) prog.push_back(enc(5, 2*i));
        if (j == 7) prog.push_back(enc(5, 2*i + 1));
      end
    end
    prog.push_back(enc(7, 0));
  endtask

  task automatic model_run(input int limit, output int steps);
    logic [31:0] ra [4];
    logic [31:0] rb [4];
    logic [31:0] ow [4];
    logic [31:0] acc;
    logic [31:0] w;
    int op, arg;
    acc = 0;
    for (int l = 0; l < 4; l++) begin ra[l] = 0; rb[l] = 0; ow[l] = 0; end
    steps = 0;
    for (int pc = 0; pc < prog.size() && steps < limit; pc++) begin
      w = prog[pc];
      op = int'(w[31:28]);
      arg = int'(w[7:0]);
      steps++;
      if (op == 7) break;
      case (op)
        1: for (int l = 0; l < 4; l++) ra[l] = ma[arg % 16][l];
        2: for (int l = 0; l < 4; l++) rb[l] = mb[arg % 16][l];
        3: for (int l = 0; l < 4; l++) acc = acc + ra[l] * rb[l];
        4: begin ow[arg % 4] = acc; acc = 0; end
        5: mres[arg % 16] = {ow[0], ow[1], ow[2], ow[3]};
        6: begin acc = 0; for (int l = 0; l < 4; l++) ow[l] = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic check_rows(input string tag);
    for (int r = 0; r < 16; r++)
      check_eq($sformatf("%s row%0d", tag, r), dut.fetch_unit.ram_result[r], mres[r]);
  endtask

  // pulse_at >= 0 injects a stray valid mid-run; abort_at >= 0 resets after that many cycles.
  task automatic run_prog(input string tag, input int pulse_at, input int abort_at);
    int exp_steps, cycles;
    load_prog();
    model_run((abort_at >= 0) ? abort_at / 2 : 1 << 30, exp_steps);
    @(negedge clk);
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    check_eq({tag, " stop_low_after_start"}, stop, 0);
    cycles = 0;
    if (abort_at >= 0) begin
      repeat (abort_at) begin @(posedge clk); #1; end
      rstn = 1'b1;
      @(posedge clk);
      #1;
      rstn = 1'b0;
      check_eq({tag, " stop_after_reset"}, stop, 0);
    end else begin
      while (!stop && cycles < 4000) begin
        valid = (cycles == pulse_at);
        @(posedge clk);
        #1;
        cycles++;
      end
      valid = 1'b0;
      check_eq({tag, " stop_cycles"}, cycles, 2 * exp_steps);
    end
    check_rows(tag);
  endtask

  task automatic rand_mats();
    for (int r = 0; r < 16; r++)
      for (int l = 0; l < 4; l++) begin
        ma[r][l] = $urandom();
        mb[r][l] = $urandom();
      end
    push_mats();
  endtask

  initial begin
    logic [31:0] rw;
    int op;
    for (int r = 0; r < 16; r++) begin
      mres[r] = '0;
      for (int l = 0; l < 4; l++) begin ma[r][l] = 0; mb[r][l] = 0; end
    end
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    check_eq("reset stop", stop, 0);

    prog.delete();
    prog.push_back(enc(6, 0));
    for (int r = 0; r < 16; r++) prog.push_back(enc(5, r));
    prog.push_back(enc(7, 0));
    push_mats();
    run_prog("clear", -1, -1);

    prog.delete();
    prog.push_back(enc(7, 0));
    run_prog("halt_only", -1, -1);

    for (int i = 0; i < 8; i++) begin
      ma[2*i + i/4][i%4] = 1;
      mb[2*i + i/4][i%4] = 1;
    end
    push_mats();
    build_mat_prog(0);
    run_prog("ident_h0", -1, -1);
    build_mat_prog(1);
    run_prog("ident_h1", -1, -1);
    check_eq("ident c00", dut.fetch_unit.ram_result[0], {32'h1, 96'h0});
    check_eq("ident c0hi", dut.fetch_unit.ram_result[1], 128'h0);
    check_eq("ident c77", dut.fetch_unit.ram_result[15], 128'h1);
    run_prog("restart", -1, -1);

    rand_mats();
    build_mat_prog(0);
    run_prog("rand_clean", -1, -1);
    run_prog("rand_stray_valid", 51, -1);
    rand_mats();
    run_prog("rand_abort", -1, 101);
    run_prog("rand_rerun", -1, -1);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    check_eq("reset_in_done stop", stop, 0);

    ma[0][0] = 32'd2; ma[0][1] = 32'hFFFF_FFFF; ma[0][2] = 0; ma[0][3] = 0;
    mb[0][0] = 32'd3; mb[0][1] = 32'd2;         mb[0][2] = 0; mb[0][3] = 0;
    push_mats();
    prog.delete();
    prog.push_back(enc(1, 0));
    prog.push_back(enc(2, 0));
    prog.push_back(enc(3, 0));
    prog.push_back(enc(4, 0));
    prog.push_back(enc(5, 0));
    prog.push_back(enc(7, 0));
    run_prog("wrap", -1, -1);
    check_eq("wrap word0", dut.fetch_unit.ram_result[0][127:96], 128'h4);

    for (int t = 0; t < 3; t++) begin
      rand_mats();
      prog.delete();
      for (int k = 0; k < 40; k++) begin
        rw = $urandom();
        op = $urandom_range(0, 15);
        if (op == 7) op = 9;
        rw[31:28] = op[3:0];
        prog.push_back(rw);
      end
      prog.push_back(enc(7, 0));
      run_prog($sformatf("rand_prog%0d", t), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
